midi_transmitter: RTL and testbench

MIDI_TRANSMITTER -- requirements
Module: midi_transmitter

---
 rtl/midi_pkg.sv | 25 ++
 rtl/midi_baud_tick.sv | 25 ++
 rtl/midi_transmitter.sv | 134 +++++++++++++
 tb/tb_midi_transmitter.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/midi_pkg.sv
// Shared MIDI transmitter types: FSM states, status-byte range limits and byte-count decode.
package midi_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

  localparam logic [7:0] ST_CHANNEL    = 8'h80;
  localparam logic [7:0] ST_TWO_BYTE   = 8'hC0;
  localparam logic [7:0] ST_PITCH_BEND = 8'hE0;
  localparam logic [7:0] ST_SYS_COMMON = 8'hF0;
  localparam logic [7:0] ST_REALTIME   = 8'hF8;

  // Bytes on the wire for a status byte; 0 marks a data byte (not a valid status).
  function automatic logic [1:0] byte_count(input logic [7:0] status);
    if (!status[7])                                           return 2'd0;
    else if (status >= ST_REALTIME)                           return 2'd1;
    else if (status >= ST_TWO_BYTE && status < ST_PITCH_BEND) return 2'd2;
    else                                                      return 2'd3;
  endfunction

endpackage

// File: rtl/midi_baud_tick.sv
// Bit-time counter: tick marks the last clock of each MIDI bit; restart realigns to bit start.
module midi_baud_tick #(
  parameter int CLKS_PER_BIT = 1600
) (
  input  logic clock,
  input  logic clr,
  input  logic restart,
  output logic tick
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (clr || restart) cnt <= '0;
    else if (cnt == LAST) cnt <= '0;
    else                  cnt <= cnt + 1'b1;
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/midi_transmitter.sv
// MIDI 8N1 serial transmitter for {status, data1, data2} messages.
// Optional running-status compression: define MIDI_TX_RUNNING_STATUS_EN.
module midi_transmitter
  import midi_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1600
) (
  input  logic        clock,
  input  logic        clr,
  input  logic [23:0] msg_bytes,
  input  logic        msg_valid,
  output logic        msg_ready,
  output logic        midi_out,
  output logic        busy,
  output logic        done
);

  tx_state_t   state;
  logic [23:0] msg_q;
  logic [7:0]  shreg;
  logic [2:0]  bit_idx;
  logic [1:0]  byte_idx;
  logic [1:0]  last_idx;
  logic        discard_done;
  logic        tick;
  logic        accept;
  logic        last_cycle;
  logic [7:0]  cur_byte;
  logic [7:0]  status;
  logic [1:0]  count;
  logic [1:0]  first_idx;

  midi_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clock   (clock),
    .clr     (clr),
    .restart (accept),
    .tick    (tick)
  );

  assign status     = msg_bytes[23:16];
  assign count      = byte_count(status);
  assign last_cycle = (state == STOP) && tick && (byte_idx == last_idx);
  assign msg_ready  = (state == IDLE) || last_cycle;
  assign accept     = msg_valid && msg_ready;
  assign done       = last_cycle || discard_done;
  assign busy       = (state != IDLE);

  always_comb begin
    case (byte_idx)
      2'd0:    cur_byte = msg_q[23:16];
      2'd1:    cur_byte = msg_q[15:8];
      default: cur_byte = msg_q[7:0];
    endcase
  end

`ifdef MIDI_TX_RUNNING_STATUS_EN
  logic [7:0] run_status;
  logic       is_channel;
  logic       is_common;

  assign is_channel = (status >= ST_CHANNEL) && (status < ST_SYS_COMMON);
  assign is_common  = (status >= ST_SYS_COMMON) && (status < ST_REALTIME);
  assign first_idx  = (is_channel && status == run_status) ? 2'd1 : 2'd0;

  always_ff @(posedge clock) begin
    if (clr)                  run_status <= '0;
    else if (accept && is_channel) run_status <= status;
    else if (accept && is_common)  run_status <= '0;
  end
`else
  assign first_idx = 2'd0;
`endif

  // NOTE: reset here is synchronous, so clr is just the highest-priority branch of the edge logic.
  always_ff @(posedge clock) begin
    discard_done <= 1'b0;
    if (clr) begin
      state    <= IDLE;
      midi_out <= 1'b1;
      msg_q    <= '0;
      shreg    <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      last_idx <= '0;
    end else if (accept) begin
      if (count == 2'd0) begin
        state        <= IDLE;
        midi_out     <= 1'b1;
        discard_done <= 1'b1;
      end else begin
        state    <= START;
        midi_out <= 1'b0;
        msg_q    <= msg_bytes;
        byte_idx <= first_idx;
        last_idx <= count - 2'd1;
      end
    end else if (tick) begin
      case (state)
        START: begin
          state    <= DATA;
          midi_out <= cur_byte[0];
          shreg    <= cur_byte >> 1;
          bit_idx  <= '0;
        end
        DATA: begin
          if (bit_idx == 3'd7) begin
            state    <= STOP;
            midi_out <= 1'b1;
          end else begin
            bit_idx  <= bit_idx + 1'b1;
            midi_out <= shreg[0];
            shreg    <= shreg >> 1;
          end
        end
        STOP: begin
          // Final stop bit with no new message falls back to idle; otherwise next byte starts immediately.
          if (byte_idx == last_idx) begin
            state    <= IDLE;
            midi_out <= 1'b1;
          end else begin
            byte_idx <= byte_idx + 1'b1;
            state    <= START;
            midi_out <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          midi_out <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_midi_transmitter.sv
// Directed self-checking bench for midi_transmitter at CLKS_PER_BIT=4.
module tb_midi_transmitter;

  localparam int CPB = 4;

  logic        clock = 1'b0;
  logic        clr;
  logic [23:0] msg_bytes;
  logic        msg_valid;
  logic        msg_ready;
  logic        midi_out;
  logic        busy;
  logic        done;

  int tests = 0;
  int fails = 0;

  midi_transmitter #(.CLKS_PER_BIT(CPB)) dut (
    .clock     (clock),
    .clr       (clr),
    .msg_bytes (msg_bytes),
    .msg_valid (msg_valid),
    .msg_ready (msg_ready),
    .midi_out  (midi_out),
    .busy      (busy),
    .done      (done)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [9:0] frame(input logic [7:0] b);
    return {1'b1, b, 1'b0};
  endfunction

  // Outputs as one nibble: {midi_out, busy, done, msg_ready}.
  function automatic logic [31:0] outs();
    return {28'd0, midi_out, busy, done, msg_ready};
  endfunction

  // Called in cycle 1 after acceptance; returns in the last cycle of the final stop bit.
  task automatic expect_line(input logic [29:0] bits, input int nbits, input string tag);
    for (int b = 0; b < nbits; b++) begin
      for (int c = 0; c < CPB; c++) begin
        logic last;
        last = (b == nbits - 1) && (c == CPB - 1);
        check($sformatf("%s b%0d c%0d", tag, b, c), outs(), {28'd0, bits[b], 1'b1, last, last});
        if (!last) step();
      end
    end
  endtask

  // Offers a message in the current cycle and returns in cycle 1 after acceptance.
  task automatic send(input logic [23:0] m, input string tag);
    msg_bytes = m;
    msg_valid = 1'b1;
    check({tag, " ready"}, {31'd0, msg_ready}, 32'd1);
    step();
    msg_valid = 1'b0;
    msg_bytes = 24'hFFFFFF;
  endtask

  initial begin
    clr       = 1'b1;
    msg_bytes = '0;
    msg_valid = 1'b0;
    step();
    step();
    check("reset", outs(), 32'h9);
    clr = 1'b0;
    step();
    step();
    check("idle", outs(), 32'h9);

    // Three-byte note-on; msg_bytes is scrambled mid-frame by send().
    send(24'h903C64, "note_on");
    expect_line({frame(8'h64), frame(8'h3C), frame(8'h90)}, 30, "note_on");
    step();
    check("note_on idle", outs(), 32'h9);

    send(24'hC00500, "prog");
    expect_line({10'd0, frame(8'h05), frame(8'hC0)}, 20, "prog");
    step();
    check("prog idle", outs(), 32'h9);

    send(24'hF80000, "clock_rt");
    expect_line({20'd0, frame(8'hF8)}, 10, "clock_rt");
    step();
    check("clock_rt idle", outs(), 32'h9);

    // Data byte in status position: discarded, done one cycle later, line stays high.
    send(24'h123456, "discard");
    check("discard done", {29'd0, midi_out, busy, done}, 32'h5);
    step();
    check("discard after", outs(), 32'h9);

    // Back-to-back: msg_valid held through the first message's final stop cycle.
    msg_valid = 1'b1;
    msg_bytes = 24'h903C64;
    check("b2b ready", {31'd0, msg_ready}, 32'd1);
    step();
    msg_bytes = 24'h803C00;
    expect_line({frame(8'h64), frame(8'h3C), frame(8'h90)}, 30, "b2b first");
    step();
    msg_valid = 1'b0;
    expect_line({frame(8'h00), frame(8'h3C), frame(8'h80)}, 30, "b2b second");
    step();
    check("b2b idle", outs(), 32'h9);

    // Abort at cycle 15 of a frame.
    send(24'h903C64, "abort");
    for (int i = 0; i < 14; i++) step();
    check("abort mid busy", {31'd0, busy}, 32'd1);
    clr = 1'b1;
    step();
    clr = 1'b0;
    check("abort after", outs(), 32'h9);
    for (int i = 0; i < 130; i++) begin
      step();
      check($sformatf("abort quiet %0d", i), {30'd0, midi_out, done}, 32'h2);
    end

    // clr wins over a simultaneous request.
    clr       = 1'b1;
    msg_valid = 1'b1;
    msg_bytes = 24'h903C64;
    step();
    clr       = 1'b0;
    msg_valid = 1'b0;
    check("clr priority", outs(), 32'h9);
    step();
    check("clr priority hold", outs(), 32'h9);

    // Repeated channel status; compressed only when running status is built in.
    send(24'h903C64, "rs first");
    expect_line({frame(8'h64), frame(8'h3C), frame(8'h90)}, 30, "rs first");
    step();
`ifdef MIDI_TX_RUNNING_STATUS_EN
    send(24'h904000, "rs second");
    expect_line({10'd0, frame(8'h00), frame(8'h40)}, 20, "rs second");
    step();
    send(24'hF80000, "rs rt");
    expect_line({20'd0, frame(8'hF8)}, 10, "rs rt");
    step();
    send(24'h904000, "rs third");
    expect_line({10'd0, frame(8'h00), frame(8'h40)}, 20, "rs third");
`else
    send(24'h904000, "rs second");
    expect_line({frame(8'h00), frame(8'h40), frame(8'h90)}, 30, "rs second");
`endif
    step();
    check("final idle", outs(), 32'h9);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
